// File: rtl/i2c_write_engine.sv
// -----------------------------------------------------------------------------
// i2c_write_engine
//
// I2C master write engine sitting directly below the init-table sequencer.
// Takes one 16-bit word {reg_addr, reg_data} and issues a three-byte write
// frame: START, SLA+W, reg_addr, reg_data, STOP. It drives open-drain SCL/SDA
// pull-down enables toward the pad IOBUFs and pulses done so the sequencer can
// advance to the next word.
//
// Every bus phase is one quarter of an SCL period, and the FSM moves only on
// tick (4x SCL rate).
//
// Parameters
//   BUS_FREE_Q  quarter-ticks of idle bus after STOP before done
//
// Ports
//   clk         system clock
//   areset_n    asynchronous reset, active low
//   tick        1-clk strobe at 4x the SCL rate
//   enable      request: start a frame when idle
//   slave_addr  7-bit target address (R/W bit is always 0)
//   wdata       [15:8] register address, [7:0] register data
//   done        1-clk pulse, coincident with a tick, at the end of a frame
//   ack_err     frame saw a NACK; valid from done until the next frame starts
//   busy        frame in progress
//   scl_oe      1 = pull SCL low, 0 = release
//   sda_oe      1 = pull SDA low, 0 = release
//   scl_in      sampled SCL pad level (used for clock stretching)
//   sda_in      sampled SDA pad level (used for the ACK slot)
// -----------------------------------------------------------------------------
module i2c_write_engine #(
   parameter int BUS_FREE_Q = 4
) (
   input  logic        clk,
   input  logic        areset_n,
   input  logic        tick,
   input  logic        enable,
   input  logic [6:0]  slave_addr,
   input  logic [15:0] wdata,
   output logic        done,
   output logic        ack_err,
   output logic        busy,
   output logic        scl_oe,
   output logic        sda_oe,
   input  logic        scl_in,
   input  logic        sda_in
);

   localparam int FREE_W = (BUS_FREE_Q > 1) ? $clog2(BUS_FREE_Q) : 1;
   localparam logic [FREE_W-1:0] FREE_LAST = FREE_W'(BUS_FREE_Q - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BIT,
      S_ACK,
      S_STOP,
      S_FREE
   } state_t;

   state_t             state, state_nxt;
   logic [1:0]         phase, phase_nxt;       // quarter of the current SCL period
   logic [2:0]         bit_cnt, bit_cnt_nxt;
   logic [1:0]         byte_cnt, byte_cnt_nxt;
   logic [FREE_W-1:0]  free_cnt, free_cnt_nxt;
   logic [23:0]        shreg, shreg_nxt;       // {SLA, W, reg_addr, reg_data}, MSB on the wire first
   logic               ack_err_nxt;
   logic               scl_oe_nxt, sda_oe_nxt;
   logic               step;

   // Pull-down pattern {scl_oe, sda_oe} for a given state/quarter. Evaluated
   // on the next-state values so the pad enables come straight from flops and
   // cannot glitch.
   function automatic logic [1:0] line_drive(input state_t s, input logic [1:0] p,
                                             input logic b);
      case (s)
         S_START: return {p[1], 1'b1};            // SDA falls first, SCL follows at q2
         S_BIT:   return {~p[1], ~b};             // SCL low q0-q1, high q2-q3
         S_ACK:   return {~p[1], 1'b0};           // SDA released for the slave
         S_STOP:  return {~p[1], p != 2'd3};      // SCL rises at q2, SDA rises at q3
         default: return 2'b00;
      endcase
   endfunction

   // A quarter in which SCL was just released only completes once the pad
   // actually reads high; a slave holding SCL low stretches the bit.
   assign step = tick && !((phase == 2'd2) && !scl_in);
   assign busy = (state != S_IDLE);

   // NOTE: every signal written here gets its default first, so no path
   // through the case statement leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      bit_cnt_nxt  = bit_cnt;
      byte_cnt_nxt = byte_cnt;
      free_cnt_nxt = free_cnt;
      shreg_nxt    = shreg;
      ack_err_nxt  = ack_err;
      done         = 1'b0;

      case (state)
         S_IDLE: begin
            if (tick && enable) begin
               shreg_nxt    = {slave_addr, 1'b0, wdata};
               ack_err_nxt  = 1'b0;
               phase_nxt    = 2'd0;
               bit_cnt_nxt  = 3'd0;
               byte_cnt_nxt = 2'd0;
               state_nxt    = S_START;
            end
         end

         // SCL is pulled low here at q2, so there is nothing to stretch.
         S_START: begin
            if (tick) begin
               phase_nxt = phase + 2'd1;
               if (phase == 2'd3) state_nxt = S_BIT;
            end
         end

         S_BIT: begin
            if (step) begin
               phase_nxt = phase + 2'd1;
               if (phase == 2'd3) begin
                  shreg_nxt = {shreg[22:0], 1'b0};
                  if (bit_cnt == 3'd7) begin
                     bit_cnt_nxt = 3'd0;
                     state_nxt   = S_ACK;
                  end else begin
                     bit_cnt_nxt = bit_cnt + 3'd1;
                  end
               end
            end
         end

         // A NACK on any byte abandons the rest of the frame.
         S_ACK: begin
            if (step) begin
               phase_nxt = phase + 2'd1;
               if (phase == 2'd3) begin
                  if (sda_in) begin
                     ack_err_nxt = 1'b1;
                     state_nxt   = S_STOP;
                  end else if (byte_cnt == 2'd2) begin
                     state_nxt = S_STOP;
                  end else begin
                     byte_cnt_nxt = byte_cnt + 2'd1;
                     state_nxt    = S_BIT;
                  end
               end
            end
         end

         S_STOP: begin
            if (step) begin
               phase_nxt = phase + 2'd1;
               if (phase == 2'd3) begin
                  free_cnt_nxt = '0;
                  state_nxt    = S_FREE;
               end
            end
         end

         S_FREE: begin
            if (tick) begin
               if (free_cnt == FREE_LAST) begin
                  done      = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  free_cnt_nxt = free_cnt + 1'b1;
               end
            end
         end

         default: state_nxt = S_IDLE;
      endcase

      {scl_oe_nxt, sda_oe_nxt} = line_drive(state_nxt, phase_nxt, shreg_nxt[23]);
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state    <= S_IDLE;
         phase    <= 2'd0;
         bit_cnt  <= 3'd0;
         byte_cnt <= 2'd0;
         free_cnt <= '0;
         // NOTE: the shift register is reset too, even though it is reloaded
         // before use; it is small and this keeps it free of X after reset.
         shreg    <= '0;
         ack_err  <= 1'b0;
         scl_oe   <= 1'b0;
         sda_oe   <= 1'b0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         bit_cnt  <= bit_cnt_nxt;
         byte_cnt <= byte_cnt_nxt;
         free_cnt <= free_cnt_nxt;
         shreg    <= shreg_nxt;
         ack_err  <= ack_err_nxt;
         scl_oe   <= scl_oe_nxt;
         sda_oe   <= sda_oe_nxt;
      end
   end

endmodule
